// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;

    localparam int unsigned STAT_W           = 16;
    localparam logic [31:0] VGA_BASE_DEFAULT = 32'h0000_0800;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIM)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority with bounded video starvation.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned VGA_AW   = 9,
    parameter logic [31:0] VGA_BASE = VGA_BASE_DEFAULT,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              vga_req,
    input  logic [VGA_AW-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STAT_W-1:0] stat_cpu_stalls,
    output logic [STAT_W-1:0] stat_vga_waits
);

    localparam int unsigned STARVE_W = $clog2(MAX_WAIT + 1);

    owner_t              owner;
    logic                cpu_grant;
    logic                vga_grant;
    logic                vga_wait;
    logic [STARVE_W-1:0] starve;
    logic [ADDR_W-1:0]   vga_byte_addr;

    // Priority select: a starved video request overrides the CPU.
    always_comb begin
        owner = OWN_NONE;
        if (vga_req && (starve == STARVE_W'(MAX_WAIT))) begin
            owner = OWN_VGA;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (vga_req) begin
            owner = OWN_VGA;
        end
    end

    assign cpu_grant = (owner == OWN_CPU);
    assign vga_grant = (owner == OWN_VGA);
    assign vga_wait  = vga_req & ~vga_grant;

    assign vga_byte_addr = ADDR_W'(VGA_BASE) + (ADDR_W'(vga_addr) << 2);

    assign mem_addr  = vga_grant ? vga_byte_addr : cpu_addr;
    assign mem_we    = cpu_grant & cpu_we;
    assign mem_wdata = cpu_wdata;
    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpu_req & ~cpu_grant;

    arb_sat_counter #(
        .WIDTH (STARVE_W),
        .LIMIT (MAX_WAIT)
    ) u_starve (
        .clk   (sysclk),
        .rst   (reset),
        .inc   (vga_wait),
        .clr   (~vga_wait),
        .count (starve)
    );

    // Video read data lands one cycle after its grant.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            vga_rvalid <= 1'b0;
            vga_rdata  <= '0;
        end else begin
            vga_rvalid <= vga_grant;
            if (vga_grant) begin
                vga_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    arb_sat_counter #(
        .WIDTH (STAT_W),
        .LIMIT ((1 << STAT_W) - 1)
    ) u_stat_cpu (
        .clk   (sysclk),
        .rst   (reset),
        .inc   (cpu_stall),
        .clr   (1'b0),
        .count (stat_cpu_stalls)
    );

    arb_sat_counter #(
        .WIDTH (STAT_W),
        .LIMIT ((1 << STAT_W) - 1)
    ) u_stat_vga (
        .clk   (sysclk),
        .rst   (reset),
        .inc   (vga_wait),
        .clr   (1'b0),
        .count (stat_vga_waits)
    );
`else
    assign stat_cpu_stalls = '0;
    assign stat_vga_waits  = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences, random traffic.
module tb_dmem_arbiter;

    localparam int unsigned MAX_WAIT = 4;
    localparam logic [31:0] VGA_BASE = 32'h0000_0800;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        vga_req;
    logic [8:0]  vga_addr;
    logic [31:0] vga_rdata;
    logic        vga_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] stat_cpu_stalls, stat_vga_waits;

    dmem_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .VGA_AW   (9),
        .VGA_BASE (VGA_BASE),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .sysclk          (sysclk),
        .reset           (reset),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_stall       (cpu_stall),
        .vga_req         (vga_req),
        .vga_addr        (vga_addr),
        .vga_rdata       (vga_rdata),
        .vga_rvalid      (vga_rvalid),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .stat_cpu_stalls (stat_cpu_stalls),
        .stat_vga_waits  (stat_vga_waits)
    );

    always #5 sysclk = ~sysclk;

    // Environment memory: combinational read, write at clock edge.
    logic [31:0] env_mem [2048];
    logic        mem_init_req;

    assign mem_rdata = env_mem[mem_addr[12:2]];

    always @(posedge sysclk) begin
        if (mem_init_req) begin
            for (int i = 0; i < 2048; i++) env_mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_we) begin
            env_mem[mem_addr[12:2]] <= mem_wdata;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [2048];
    int          m_refused;
    logic        m_rv;
    logic [31:0] m_vrdata;
    int          m_stalls, m_waits;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] exp_stat(int n);
`ifdef DMEM_ARB_STATS_EN
        return (n > 65535) ? 32'h0000_FFFF : 32'(n);
`else
        return (n < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    function automatic void model_reset();
        m_refused = 0;
        m_rv      = 1'b0;
        m_vrdata  = 32'h0;
        m_stalls  = 0;
        m_waits   = 0;
    endfunction

    // Drive one cycle's inputs, compare against the model, then advance the model.
    task automatic apply(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic vreq, input logic [8:0] vaddr);
        logic        vga_win, cpu_win, e_we;
        logic [31:0] e_addr;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwd;
        vga_req   = vreq;
        vga_addr  = vaddr;
        #1;
        vga_win = vreq && (!creq || m_refused >= int'(MAX_WAIT));
        cpu_win = creq && !vga_win;
        e_addr  = vga_win ? (VGA_BASE + 32'(vaddr) * 32'd4) : caddr;
        e_we    = cpu_win && cwe;
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("cpu_stall", 32'(cpu_stall), 32'(creq && !cpu_win));
        if (e_we) chk("mem_wdata", mem_wdata, cwd);
        if (cpu_win && !cwe) chk("cpu_rdata", cpu_rdata, ref_mem[caddr[12:2]]);
        chk("vga_rvalid", 32'(vga_rvalid), 32'(m_rv));
        chk("vga_rdata", vga_rdata, m_vrdata);
        chk("stat_cpu_stalls", 32'(stat_cpu_stalls), exp_stat(m_stalls));
        chk("stat_vga_waits", 32'(stat_vga_waits), exp_stat(m_waits));
        if (e_we) ref_mem[caddr[12:2]] = cwd;
        m_rv = vga_win;
        if (vga_win) m_vrdata = ref_mem[e_addr[12:2]];
        if (vga_win || !vreq) m_refused = 0;
        else m_refused++;
        if (creq && !cpu_win) m_stalls++;
        if (vreq && !vga_win) m_waits++;
    endtask

    task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr,
                        input logic [31:0] cwd, input logic vreq, input logic [8:0] vaddr);
        @(negedge sysclk);
        apply(creq, cwe, caddr, cwd, vreq, vaddr);
    endtask

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [31:0] caddr;
        logic [31:0] cwd;
        logic        vreq;
        logic [8:0]  vaddr;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_stall;
        logic        e_rv;
        logic        chk_crd;
        logic [31:0] e_crd;
        logic        chk_vrd;
        logic [31:0] e_vrd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        reset        = 1'b1;
        mem_init_req = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        vga_req = 1'b0; vga_addr = 9'h0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        model_reset();

        vecs[0] = '{1'b1, 1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 9'd0,   1'b1, 32'h10,  1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,         1'b0, 9'd0,   1'b0, 32'h10,  1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h80C, 32'hCAFE_F00D, 1'b0, 9'd0,   1'b1, 32'h80C, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h20,  32'h0,         1'b1, 9'd3,   1'b0, 32'h80C, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h20,  32'h0,         1'b0, 9'd0,   1'b0, 32'h20,  1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b0, 32'h10,  32'h0,         1'b1, 9'd5,   1'b0, 32'h10,  1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b0, 32'h20,  32'h0,         1'b1, 9'd5,   1'b0, 32'h814, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 9'd0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hA500_0205};
        vecs[8] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 9'd511, 1'b0, 32'hFFC, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[9] = '{1'b1, 1'b1, 32'h24,  32'h1111_2222, 1'b0, 9'd0,   1'b1, 32'h24,  1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hA500_03FF};

        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        chk("reset_vga_rvalid", 32'(vga_rvalid), 32'h0);
        chk("reset_vga_rdata", vga_rdata, 32'h0);
        chk("reset_stat_cpu", 32'(stat_cpu_stalls), 32'h0);
        chk("reset_stat_vga", 32'(stat_vga_waits), 32'h0);
        reset        = 1'b0;
        mem_init_req = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd, vecs[i].vreq, vecs[i].vaddr);
            chk("vec_mem_we", 32'(mem_we), 32'(vecs[i].e_we));
            chk("vec_mem_addr", mem_addr, vecs[i].e_addr);
            chk("vec_cpu_stall", 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk("vec_vga_rvalid", 32'(vga_rvalid), 32'(vecs[i].e_rv));
            if (vecs[i].chk_crd) chk("vec_cpu_rdata", cpu_rdata, vecs[i].e_crd);
            if (vecs[i].chk_vrd) chk("vec_vga_rdata", vga_rdata, vecs[i].e_vrd);
        end

        // Build up starvation, then reset while the video grant is due.
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 9'd7);
        @(negedge sysclk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; vga_req = 1'b1; vga_addr = 9'd7;
        reset = 1'b1;
        #1;
        chk("rst_mid_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("rst_mid_mem_addr", mem_addr, 32'h40);
        chk("rst_mid_vga_rvalid", 32'(vga_rvalid), 32'h0);
        chk("rst_mid_vga_rdata", vga_rdata, 32'h0);
        chk("rst_mid_stat_cpu", 32'(stat_cpu_stalls), 32'h0);
        chk("rst_mid_stat_vga", 32'(stat_vga_waits), 32'h0);
        @(negedge sysclk);
        #1;
        chk("rst_hold_vga_rvalid", 32'(vga_rvalid), 32'h0);
        model_reset();
        reset = 1'b0;

        // 20-cycle contention: video wins on cycles 4, 9, 14, 19.
        apply(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 9'd0);
        chk("contention_stall_0", 32'(cpu_stall), 32'h0);
        for (int c = 1; c < 20; c++) begin
            step(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 9'(c));
            chk("contention_stall", 32'(cpu_stall), (c % 5 == 4) ? 32'h1 : 32'h0);
        end
        @(negedge sysclk);
        #1;
`ifdef DMEM_ARB_STATS_EN
        chk("contention_stat_cpu", 32'(stat_cpu_stalls), 32'd4);
        chk("contention_stat_vga", 32'(stat_vga_waits), 32'd16);
`else
        chk("contention_stat_cpu", 32'(stat_cpu_stalls), 32'd0);
        chk("contention_stat_vga", 32'(stat_vga_waits), 32'd0);
`endif
        chk("contention_vga_rvalid", 32'(vga_rvalid), 32'h1);
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 9'd0);

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            logic        rc, rw, rv;
            logic [31:0] ra;
            rc = ($urandom_range(0, 99) < 65);
            rw = $urandom_range(0, 1) == 1;
            ra = 32'($urandom_range(0, 2047)) << 2;
            rv = ($urandom_range(0, 99) < 55);
            step(rc, rw, ra, $urandom, rv, 9'($urandom_range(0, 511)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory between the ARM core and the VGA frame fetcher. Grants one requester per cycle, with CPU priority and a bounded-wait guarantee for video. The CPU sees same-cycle combinational read data, or a stall. Video sees registered read data one cycle after its grant. It sits between `arm`/`vga` and `dmem`, and replaces their direct wiring.

## Interface
Parameters:
- `DATA_W`, 32, memory word width
- `ADDR_W`, 32, byte address width on the CPU and memory sides
- `VGA_AW`, 9, video word-address width
- `VGA_BASE`, 32'h0000_0800, byte address of video word 0
- `MAX_WAIT`, 4, maximum consecutive cycles a video request may be refused (≥1)

Ports:
- `sysclk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `cpu_req` in 1: CPU memory access this cycle (load or store)
- `cpu_we` in 1: store
- `cpu_addr` in ADDR_W: byte address
- `cpu_wdata` in DATA_W: store data
- `cpu_rdata` out DATA_W: load data, combinational
- `cpu_stall` out 1: CPU access refused; core holds PC and state
- `vga_req` in 1: video word read request
- `vga_addr` in VGA_AW: video word index
- `vga_rdata` out DATA_W: registered read data
- `vga_rvalid` out 1: one-cycle pulse, `vga_rdata` valid
- `mem_we` out 1: memory write enable
- `mem_addr` out ADDR_W: memory byte address
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory combinational read data
- `stat_cpu_stalls` out 16: saturating stall count
- `stat_vga_waits` out 16: saturating video-wait count

## Operation
- Grant decision is combinational each cycle. Evaluate in this order:
  1. If `vga_req` and `starve == MAX_WAIT`: grant VGA.
  2. Else if `cpu_req`: grant CPU.
  3. Else if `vga_req`: grant VGA.
  4. Else: no grant.
- CPU grant:
  - `mem_addr = cpu_addr`, `mem_wdata = cpu_wdata`, `mem_we = cpu_we`.
  - `cpu_rdata = mem_rdata`.
- VGA grant:
  - `mem_addr = VGA_BASE + (vga_addr << 2)`, computed in ADDR_W bits with wrap-around.
  - `mem_we = 0`.
- No grant: `mem_we = 0`, `mem_addr = cpu_addr`.
- `mem_we` is never 1 unless the CPU is granted.
- `cpu_stall = cpu_req & ~cpu_grant`. A stalled CPU re-presents the same access next cycle.
- `starve` register, width `$clog2(MAX_WAIT+1)`:
  - Increments when `vga_req & ~vga_grant`, saturating at MAX_WAIT.
  - Clears when the VGA is granted or `vga_req` is 0.
- VGA data path:
  - On a VGA grant, `vga_rdata <= mem_rdata` and `vga_rvalid <= 1`.
  - Otherwise `vga_rvalid <= 0` and `vga_rdata` holds.
- Simultaneous requests with `starve < MAX_WAIT`: the CPU wins and `starve` increments.
- `cpu_req` held permanently high: the VGA is granted at least once every MAX_WAIT+1 cycles.
- Reset (any time, including mid-stall):
  - `starve = 0`, `vga_rvalid = 0`, `vga_rdata = 0`, statistics = 0.
  - A pending VGA grant is dropped with no `vga_rvalid`.
  - Combinational outputs follow the inputs immediately.

## Timing
- CPU access: zero added latency when granted. Each lost cycle adds one stall cycle, at most one per MAX_WAIT+1 cycles under continuous video demand.
- VGA read: `vga_rvalid` rises exactly 1 cycle after the grant cycle. Worst-case request-to-valid latency is MAX_WAIT+1 cycles.
- Writes take effect at the `sysclk` edge ending the grant cycle. A VGA read of the same word in the next cycle returns the new data.
- The grant path is a single comparator plus a priority mux; no multi-cycle paths.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - `stat_cpu_stalls` increments each cycle `cpu_stall` is 1.
  - `stat_vga_waits` increments each cycle `vga_req & ~vga_grant`.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined: both statistics ports are tied to 0 and no counter flops are synthesised. The port list is unchanged, so `top` needs no edit.

## Structure
- `dmem_arb_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t`
  - `STAT_W = 16`
  - Default `VGA_BASE`
- Sub-module `arb_sat_counter`:
  - Parameterised width and limit; inputs `inc` and `clr`; asynchronous active-high reset.
  - Used for `starve` and for both statistics counters.

## Test plan
- Reset asserted mid-stream with `vga_req=1`, `cpu_req=1` -> `vga_rvalid=0`, `starve=0`, statistics 0; the following cycle grants the CPU.
- CPU-only store `cpu_addr=0x10`, `cpu_wdata=0xDEADBEEF`, then a load from 0x10 -> `mem_we=1` in cycle 0, `cpu_rdata=0xDEADBEEF` in cycle 1, `cpu_stall=0` throughout.
- VGA-only read `vga_addr=3` -> `mem_addr=0x80C`; `vga_rvalid=1` next cycle with the word at 0x80C.
- `cpu_req` and `vga_req` held high for 20 cycles with MAX_WAIT=4 -> VGA granted on cycles 4, 9, 14, 19; `cpu_stall=1` exactly on those cycles.
- CPU store to 0x80C, with a VGA read of `vga_addr=3` granted the next cycle -> `vga_rdata` equals the stored value.
- With `DMEM_ARB_STATS_EN`, run the 20-cycle contention scenario -> `stat_cpu_stalls=4`, `stat_vga_waits=16`. Without the macro, both read 0.
